// File: rtl/cmp_pkg.sv
// Shared encodings for the compare/flag unit and the condition evaluator.
`default_nettype none

package cmp_pkg;

  localparam logic [1:0] MODE_CMP = 2'b00;
  localparam logic [1:0] MODE_CMN = 2'b01;
  localparam logic [1:0] MODE_TST = 2'b10;
  localparam logic [1:0] MODE_TEQ = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One in-flight operation: N/Z plus raw C/V, and whether C/V must be kept.
  typedef struct packed {
    logic is_logic;
    logic n;
    logic z;
    logic c;
    logic v;
  } flag_op_t;

endpackage

`default_nettype wire

// File: rtl/cmp_flag_unit_cond_eval.sv
// Combinational ARM condition-code evaluation against an NZCV nibble.
`default_nettype none

module cond_eval
  import cmp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cmp_flag_unit.sv
// Pipelined CMP/CMN/TST/TEQ flag generator owning the architectural NZCV register.
`default_nettype none

module cmp_flag_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       mode,
  input  logic             flush,
  input  logic             flag_wr_en,
  input  logic [3:0]       flag_wr_data,
  output logic [3:0]       flags,
  output logic             flags_valid,
  input  logic [3:0]       cond,
  output logic             cond_pass
);

  logic [WIDTH-1:0] addend;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] result;
  flag_op_t         issue_op;

  // CMP is in1 + ~in2 + 1 so the carry out directly means "no borrow".
  always_comb begin
    addend    = (mode == MODE_CMP) ? ~in2 : in2;
    carry_in  = (mode == MODE_CMP);
    sum       = {1'b0, in1} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};
    logic_res = (mode == MODE_TST) ? (in1 & in2) : (in1 ^ in2);
    result    = (mode == MODE_TST || mode == MODE_TEQ) ? logic_res : sum[WIDTH-1:0];

    issue_op.is_logic = (mode == MODE_TST || mode == MODE_TEQ);
    issue_op.n        = result[WIDTH-1];
    issue_op.z        = (result == '0);
    issue_op.c        = sum[WIDTH];
    issue_op.v        = (in1[WIDTH-1] == addend[WIDTH-1]) &&
                        (sum[WIDTH-1] != in1[WIDTH-1]);
  end

  logic     stage_valid;
  flag_op_t stage_op;
  logic     commit_valid;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic     s1_valid;
      flag_op_t s1_op;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_op    <= '0;
        end else begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_op <= issue_op;
          end
        end
      end

      assign stage_valid = s1_valid;
      assign stage_op    = s1_op;
    end else begin : g_pipe1
      assign stage_valid = in_valid;
      assign stage_op    = issue_op;
    end
  endgenerate

  // With a single stage nothing is ever in flight, so flush cannot kill anything.
  assign commit_valid = stage_valid && !(flush && (PIPE == 2));

  // TST/TEQ read C/V from the register at commit, which already holds the
  // result of any op that committed on the preceding edge.
  logic [3:0] next_flags;

  always_comb begin
    next_flags         = flags;
    next_flags[FLAG_N] = stage_op.n;
    next_flags[FLAG_Z] = stage_op.z;
    next_flags[FLAG_C] = stage_op.is_logic ? flags[FLAG_C] : stage_op.c;
    next_flags[FLAG_V] = stage_op.is_logic ? flags[FLAG_V] : stage_op.v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags       <= 4'b0000;
      flags_valid <= 1'b0;
    end else if (flag_wr_en) begin
      flags       <= flag_wr_data;
      flags_valid <= 1'b0;
    end else if (commit_valid) begin
      flags       <= next_flags;
      flags_valid <= 1'b1;
    end else begin
      flags_valid <= 1'b0;
    end
  end

  cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags),
    .cond_pass (cond_pass)
  );

endmodule

`default_nettype wire

// File: tb/tb_cmp_flag_unit.sv
// Directed scoreboard bench for cmp_flag_unit, one instance per pipeline depth.
`default_nettype none

module tb_cmp_flag_unit;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        p1_in_valid, p1_flush, p1_wr_en, p1_fv, p1_pass;
  logic [31:0] p1_in1, p1_in2;
  logic [1:0]  p1_mode;
  logic [3:0]  p1_wr_data, p1_flags, p1_cond;

  logic        p2_in_valid, p2_flush, p2_wr_en, p2_fv, p2_pass;
  logic [31:0] p2_in1, p2_in2;
  logic [1:0]  p2_mode;
  logic [3:0]  p2_wr_data, p2_flags, p2_cond;

  int vectors = 0;
  int errors  = 0;

  logic [3:0] q1[$];
  logic [3:0] q2[$];
  logic [3:0] m1 = 4'b0000;
  logic [3:0] m2 = 4'b0000;
  logic [3:0] e1, e2;

  always #5 clk = ~clk;

  cmp_flag_unit #(.WIDTH(32), .PIPE(1)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(p1_in_valid), .in1(p1_in1), .in2(p1_in2),
    .mode(p1_mode), .flush(p1_flush), .flag_wr_en(p1_wr_en), .flag_wr_data(p1_wr_data),
    .flags(p1_flags), .flags_valid(p1_fv), .cond(p1_cond), .cond_pass(p1_pass)
  );

  cmp_flag_unit #(.WIDTH(32), .PIPE(2)) u_p2 (
    .clk(clk), .rst(rst), .in_valid(p2_in_valid), .in1(p2_in1), .in2(p2_in2),
    .mode(p2_mode), .flush(p2_flush), .flag_wr_en(p2_wr_en), .flag_wr_data(p2_wr_data),
    .flags(p2_flags), .flags_valid(p2_fv), .cond(p2_cond), .cond_pass(p2_pass)
  );

  // Reference flags from wide signed/unsigned arithmetic.
  function automatic logic [3:0] flag_model(logic [1:0] m, logic [31:0] a, logic [31:0] b,
                                            logic [3:0] prev);
    logic [31:0] r;
    longint      s;
    logic        c, v;
    c = prev[1];
    v = prev[0];
    case (m)
      MODE_CMP: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        c = (a >= b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      MODE_CMN: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        c = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      MODE_TST: r = a & b;
      default:  r = a ^ b;
    endcase
    return {r[31], (r == 32'd0), c, v};
  endfunction

  // Even codes test a predicate, odd codes invert it; 1111 is never.
  function automatic logic cond_model(logic [3:0] cc, logic [3:0] f);
    logic base;
    case (cc[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic p1_issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    p1_in_valid = 1'b1; p1_mode = m; p1_in1 = a; p1_in2 = b;
    m1 = flag_model(m, a, b, m1);
    q1.push_back(m1);
  endtask

  task automatic p2_issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    p2_in_valid = 1'b1; p2_mode = m; p2_in1 = a; p2_in2 = b;
    m2 = flag_model(m, a, b, m2);
    q2.push_back(m2);
  endtask

  // Scoreboard: every flags_valid pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (p1_fv === 1'b1) begin
      if (q1.size() == 0) begin
        vectors++; errors++;
        $error("FAIL p1 sb: unexpected flags_valid, observed flags %b expected none", p1_flags);
      end else begin
        e1 = q1.pop_front();
        chk("p1 sb", p1_flags, e1);
      end
    end
    if (p2_fv === 1'b1) begin
      if (q2.size() == 0) begin
        vectors++; errors++;
        $error("FAIL p2 sb: unexpected flags_valid, observed flags %b expected none", p2_flags);
      end else begin
        e2 = q2.pop_front();
        chk("p2 sb", p2_flags, e2);
      end
    end
  end

  initial begin
    p1_in_valid = 0; p1_in1 = 0; p1_in2 = 0; p1_mode = 0; p1_flush = 0;
    p1_wr_en = 0; p1_wr_data = 0; p1_cond = COND_AL;
    p2_in_valid = 0; p2_in1 = 0; p2_in2 = 0; p2_mode = 0; p2_flush = 0;
    p2_wr_en = 0; p2_wr_data = 0; p2_cond = COND_AL;

    #1 rst = 1'b1;
    #1;
    chk("p1 reset flags", p1_flags, 4'b0000);
    chk("p1 reset valid", {3'b0, p1_fv}, 4'd0);
    chk("p2 reset flags", p2_flags, 4'b0000);
    chk("p2 reset valid", {3'b0, p2_fv}, 4'd0);
    tick();
    rst = 1'b0;
    tick();

    // ---- PIPE=1 ----
    p1_issue(MODE_CMP, 32'd5, 32'd5);
    tick();
    chk("p1 cmp5 flags", p1_flags, 4'b0110);
    chk("p1 cmp5 valid", {3'b0, p1_fv}, 4'd1);
    p1_in_valid = 0;
    p1_cond = COND_EQ; #1 chk("p1 cond EQ", {3'b0, p1_pass}, 4'd1);
    p1_cond = COND_HI; #1 chk("p1 cond HI", {3'b0, p1_pass}, 4'd0);
    tick();
    chk("p1 valid drop", {3'b0, p1_fv}, 4'd0);

    p1_issue(MODE_CMP, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    tick();
    chk("p1 cmp ovf flags", p1_flags, 4'b1001);
    p1_cond = COND_GE; #1 chk("p1 cond GE", {3'b0, p1_pass}, 4'd1);
    p1_cond = COND_LT; #1 chk("p1 cond LT", {3'b0, p1_pass}, 4'd0);
    p1_issue(MODE_CMP, 32'd0, 32'd1);
    tick();
    chk("p1 cmp 0-1 flags", p1_flags, 4'b1000);
    p1_cond = COND_CC; #1 chk("p1 cond CC", {3'b0, p1_pass}, 4'd1);
    p1_issue(MODE_CMN, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("p1 cmn flags", p1_flags, 4'b0110);
    p1_issue(MODE_TST, 32'h0F, 32'hF0);
    tick();
    chk("p1 tst flags", p1_flags, 4'b0110);
    p1_issue(MODE_TEQ, 32'h8000_0000, 32'd0);
    tick();
    chk("p1 teq flags", p1_flags, 4'b1010);
    p1_issue(MODE_CMP, 32'd3, 32'd3);
    tick();
    chk("p1 b2b flags", p1_flags, 4'b0110);
    p1_in_valid = 0;
    for (int c = 0; c < 16; c++) begin
      p1_cond = 4'(c);
      #1 chk($sformatf("p1 cond %0d f=0110", c), {3'b0, p1_pass},
             {3'b0, cond_model(4'(c), 4'b0110)});
    end
    tick();
    p1_wr_en = 1; p1_wr_data = 4'b1001;
    tick();
    p1_wr_en = 0; m1 = 4'b1001;
    chk("p1 wr flags", p1_flags, 4'b1001);
    chk("p1 wr no valid", {3'b0, p1_fv}, 4'd0);
    for (int c = 0; c < 16; c++) begin
      p1_cond = 4'(c);
      #1 chk($sformatf("p1 cond %0d f=1001", c), {3'b0, p1_pass},
             {3'b0, cond_model(4'(c), 4'b1001)});
    end
    tick();

    // ---- PIPE=2: back-to-back commits one cycle apart ----
    p2_issue(MODE_CMP, 32'd3, 32'd7);
    tick();
    chk("p2 lat flags", p2_flags, 4'b0000);
    chk("p2 lat valid", {3'b0, p2_fv}, 4'd0);
    p2_issue(MODE_CMP, 32'd7, 32'd3);
    tick();
    chk("p2 op1 flags", p2_flags, 4'b1000);
    chk("p2 op1 valid", {3'b0, p2_fv}, 4'd1);
    p2_in_valid = 0;
    tick();
    chk("p2 op2 flags", p2_flags, 4'b0010);
    chk("p2 op2 valid", {3'b0, p2_fv}, 4'd1);
    tick();
    chk("p2 idle valid", {3'b0, p2_fv}, 4'd0);

    // TST right behind CMP picks up the C that CMP commits
    p2_issue(MODE_CMP, 32'd1, 32'd1);
    tick();
    p2_issue(MODE_TST, 32'hFF, 32'h01);
    tick();
    p2_in_valid = 0;
    tick();
    chk("p2 fwd flags", p2_flags, 4'b0010);

    // Flush kills the stage-1 op while a new op is accepted
    p2_in_valid = 1; p2_mode = MODE_CMP; p2_in1 = 32'd1; p2_in2 = 32'd2;
    tick();
    p2_issue(MODE_CMP, 32'd9, 32'd9);
    p2_flush = 1;
    tick();
    p2_flush = 0; p2_in_valid = 0;
    chk("p2 flush flags", p2_flags, 4'b0010);
    chk("p2 flush valid", {3'b0, p2_fv}, 4'd0);
    tick();
    chk("p2 post-flush flags", p2_flags, 4'b0110);
    chk("p2 post-flush valid", {3'b0, p2_fv}, 4'd1);
    tick();
    chk("p2 post-flush drop", {3'b0, p2_fv}, 4'd0);

    // Direct write collides with a commit and wins
    p2_in_valid = 1; p2_mode = MODE_CMP; p2_in1 = 32'd3; p2_in2 = 32'd7;
    tick();
    p2_in_valid = 0; p2_wr_en = 1; p2_wr_data = 4'b1111;
    tick();
    p2_wr_en = 0; m2 = 4'b1111;
    chk("p2 wr flags", p2_flags, 4'b1111);
    chk("p2 wr valid", {3'b0, p2_fv}, 4'd0);
    tick();
    chk("p2 wr drop", {3'b0, p2_fv}, 4'd0);
    p2_issue(MODE_TEQ, 32'd1, 32'd1);
    tick();
    p2_in_valid = 0;
    tick();
    chk("p2 teq keeps CV", p2_flags, 4'b0111);
    tick();

    // Reset mid-pipeline: immediate clear and the in-flight op never lands
    p2_in_valid = 1; p2_mode = MODE_CMP; p2_in1 = 32'd3; p2_in2 = 32'd7;
    tick();
    p2_in_valid = 0;
    rst = 1'b1;
    #1;
    chk("p2 async rst flags", p2_flags, 4'b0000);
    chk("p2 async rst valid", {3'b0, p2_fv}, 4'd0);
    tick();
    rst = 1'b0; m1 = 4'b0000; m2 = 4'b0000;
    tick();
    tick();
    chk("p2 post-rst flags", p2_flags, 4'b0000);
    chk("p2 post-rst valid", {3'b0, p2_fv}, 4'd0);

    chk("p1 sb drained", 4'(q1.size()), 4'd0);
    chk("p2 sb drained", 4'(q2.size()), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
